// File: rtl/scan_sel_gen.sv
// Select sequencer for a 2-to-4 decoder: steps sel through 0..last at a DIV-cycle slot rate.
// Optional blanking gap between slots is compiled in with `define SCAN_BLANK_EN.
module scan_sel_gen #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned BLANK_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] last,
  input  logic       hold,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       wrap
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIV - 1);

  if (DIV < 2 || DIV > 65535 || BLANK_CYC < 1 || BLANK_CYC > 255) begin : g_bad_param
    $error("scan_sel_gen: DIV or BLANK_CYC out of range");
  end

`ifdef SCAN_BLANK_EN
  localparam int unsigned BCNT_W = 8;
  localparam logic [BCNT_W-1:0] BLANK_LAST = BCNT_W'(BLANK_CYC - 1);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
`else
  typedef enum logic [1:0] {IDLE, SHOW} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  // Next index; >= keeps a mid-frame reduction of last from overrunning
  logic [1:0] adv_sel;
  logic       adv_wrap;
  always_comb begin
    adv_wrap = (sel_q >= last);
    adv_sel  = adv_wrap ? 2'd0 : sel_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef SCAN_BLANK_EN
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
`ifdef SCAN_BLANK_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
`ifdef SCAN_BLANK_EN
    bcnt_d  = bcnt_q;
`endif
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = 2'd0;
      valid_d = 1'b0;
`ifdef SCAN_BLANK_EN
      bcnt_d  = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SHOW;
          cnt_d   = '0;
          sel_d   = 2'd0;
          valid_d = 1'b1;
        end
        SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            cnt_d = '0;
            if (!hold) begin
`ifdef SCAN_BLANK_EN
              state_d = BLANK;
              valid_d = 1'b0;
              bcnt_d  = '0;
`else
              sel_d  = adv_sel;
              wrap_d = adv_wrap;
`endif
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          if (bcnt_q == BLANK_LAST) begin
            state_d = SHOW;
            sel_d   = adv_sel;
            wrap_d  = adv_wrap;
            valid_d = 1'b1;
            cnt_d   = '0;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = 2'd0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign sel_valid = valid_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed bench for scan_sel_gen (DIV=4, BLANK_CYC=1); follows SCAN_BLANK_EN like the RTL.
module tb_scan_sel_gen;

  localparam int unsigned DIV       = 4;
  localparam int unsigned BLANK_CYC = 1;
`ifdef SCAN_BLANK_EN
  localparam int BL = 1;
`else
  localparam int BL = 0;
`endif
  localparam int SLOT = DIV + BL;

  logic       clk = 1'b0;
  logic       rst, en, hold;
  logic [1:0] last;
  logic [1:0] sel;
  logic       sel_valid, wrap;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  scan_sel_gen #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst(rst), .en(en), .last(last), .hold(hold),
    .sel(sel), .sel_valid(sel_valid), .wrap(wrap)
  );

  // Leave IDLE cleanly; returns at the first SHOW cycle (k=0)
  task automatic restart(input logic [1:0] lst);
    rst = 1'b0; hold = 1'b0; en = 1'b0; last = lst;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; hold = 1'b1; last = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({sel, sel_valid, wrap} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset cyc%0d: sel=%0d valid=%b wrap=%b, want 0/0/0", i, sel, sel_valid, wrap);
      end
    end
    rst = 1'b0; hold = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({sel, sel_valid, wrap} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_exit: sel=%0d valid=%b wrap=%b, want 0/1/0", sel, sel_valid, wrap);
    end
  endtask

  task automatic test_full_scan;
    int s, p;
    logic [1:0] es;
    logic ev, ew;
    restart(2'd3);
    for (int k = 0; k < 9 * SLOT; k++) begin
      s = k / SLOT; p = k % SLOT;
      es = 2'(s % 4);
      ev = (p < int'(DIV));
      ew = (p == 0) && (s > 0) && (es == 2'd0);
      n_tests++;
      if (sel !== es || sel_valid !== ev || wrap !== ew) begin
        n_fail++;
        $display("FAIL full_scan k=%0d: sel=%0d valid=%b wrap=%b, want %0d/%b/%b",
                 k, sel, sel_valid, wrap, es, ev, ew);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_short_scan;
    int s, p;
    logic [1:0] es;
    logic ev, ew;
    restart(2'd1);
    for (int k = 0; k < 5 * SLOT; k++) begin
      s = k / SLOT; p = k % SLOT;
      es = 2'(s % 2);
      ev = (p < int'(DIV));
      ew = (p == 0) && (s > 0) && (es == 2'd0);
      n_tests++;
      if (sel !== es || sel_valid !== ev || wrap !== ew) begin
        n_fail++;
        $display("FAIL short_scan k=%0d: sel=%0d valid=%b wrap=%b, want %0d/%b/%b",
                 k, sel, sel_valid, wrap, es, ev, ew);
      end
      @(negedge clk);
    end
    // sel=1 slot is showing; shrink last to 0
    last = 2'd0;
    for (int k = 5 * SLOT; k <= 7 * SLOT; k++) begin
      p  = k % SLOT;
      es = (k < 6 * SLOT) ? 2'd1 : 2'd0;
      ev = (p < int'(DIV));
      ew = (p == 0) && (k >= 6 * SLOT);
      n_tests++;
      if (sel !== es || sel_valid !== ev || wrap !== ew) begin
        n_fail++;
        $display("FAIL last_shrink k=%0d: sel=%0d valid=%b wrap=%b, want %0d/%b/%b",
                 k, sel, sel_valid, wrap, es, ev, ew);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold;
    int base;
    logic [1:0] es;
    logic ev;
    restart(2'd3);
    base = 2 * SLOT;
    repeat (base) @(negedge clk);
    hold = 1'b1;
    for (int k = base; k <= base + 16 + BL; k++) begin
      if (k == base + 12) hold = 1'b0;
      es = (k < base + 16 + BL) ? 2'd2 : 2'd3;
      ev = !(BL == 1 && k == base + 16);
      n_tests++;
      if (sel !== es || sel_valid !== ev || wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL hold k=%0d: sel=%0d valid=%b wrap=%b, want %0d/%b/0",
                 k, sel, sel_valid, wrap, es, ev);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_disable;
    int kd;
    kd = (BL == 1) ? SLOT + int'(DIV) : SLOT + 2;
    restart(2'd3);
    repeat (kd) @(negedge clk);
    n_tests++;
    if (sel !== 2'd1 || sel_valid !== 1'(BL == 0)) begin
      n_fail++;
      $display("FAIL disable_pre: sel=%0d valid=%b, want 1/%b", sel, sel_valid, 1'(BL == 0));
    end
    en = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({sel, sel_valid, wrap} !== 4'b0000) begin
      n_fail++;
      $display("FAIL disable: sel=%0d valid=%b wrap=%b, want 0/0/0", sel, sel_valid, wrap);
    end
    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= SLOT; k++) begin
      n_tests++;
      if (sel !== ((k == SLOT) ? 2'd1 : 2'd0) || sel_valid !== (k < int'(DIV) || k == SLOT) ||
          wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL reenable k=%0d: sel=%0d valid=%b wrap=%b", k, sel, sel_valid, wrap);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    restart(2'd3);
    repeat (2 * SLOT + 1) @(negedge clk);
    n_tests++;
    if (sel !== 2'd2 || sel_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: sel=%0d valid=%b, want 2/1", sel, sel_valid);
    end
    rst = 1'b1; hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if ({sel, sel_valid, wrap} !== 4'b0000) begin
        n_fail++;
        $display("FAIL rst_mid cyc%0d: sel=%0d valid=%b wrap=%b, want 0/0/0", i, sel, sel_valid, wrap);
      end
    end
    rst = 1'b0; hold = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({sel, sel_valid, wrap} !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_mid_exit: sel=%0d valid=%b wrap=%b, want 0/1/0", sel, sel_valid, wrap);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; hold = 1'b0; last = 2'd3;
    test_reset();
    test_full_scan();
    test_short_scan();
    test_hold();
    test_disable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
